// File: rtl/vram_sdp_ctrl.sv
// Simple-dual-port video RAM with a whole-memory fill engine and an optional output register.
// Build option: define VRAM_SDP_BYPASS_EN to forward same-edge write data to a colliding read.
module vram_sdp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_valid,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // state    | meaning
  // ST_IDLE  | waiting for clr_start; external writes own the write port
  // ST_FILL  | writing the latched fill value to cnt_q, one word per cycle
  // ST_DONE  | single-cycle completion pulse, then back to idle
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic                  wr_drop_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_valid_q;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      wr_drop_q  <= we & clr_busy;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          fill_val_d = clr_value;
          cnt_d      = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        cnt_d = cnt_q + 1'b1;
        // last word written when the counter is about to wrap
        if (&cnt_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_busy = (state_q == ST_FILL);
  assign clr_done = (state_q == ST_DONE);
  assign wr_drop  = wr_drop_q;

  // fill engine takes the write port outright; external writes are dropped meanwhile
  assign mem_we = clr_busy | we;
  assign mem_wa = clr_busy ? cnt_q : wa;
  assign mem_wd = clr_busy ? fill_val_q : wd;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef VRAM_SDP_BYPASS_EN
  assign rdata_c = (mem_we && (mem_wa == ra)) ? mem_wd : mem[ra];
`else
  assign rdata_c = mem[ra];
`endif

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  v1_q;

    always_ff @(posedge clk) begin
      if (re) ram_q <= rdata_c;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1_q       <= 1'b0;
        rd_q       <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        v1_q       <= re;
        rd_valid_q <= v1_q;
        if (v1_q) rd_q <= ram_q;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q       <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= re;
        if (re) rd_q <= rdata_c;
      end
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/vram_sdp_ctrl.md
VRAM_SDP_CTRL -- requirements
Module: vram_sdp_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUT_REG, default 1, 1 = registered output (read latency 2), 0 = read latency 1.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port we  input  1  write enable, one word per cycle.
REQ-007 SHALL have port wa  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port wd  input  DATA_WIDTH  write data.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port ra  input  ADDR_WIDTH  read address.
REQ-011 SHALL have port rd  output  DATA_WIDTH  read data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse marking rd as the result of a read.
REQ-013 SHALL have port clr_start  input  1  pulse requesting a fill of the whole memory.
REQ-014 SHALL have port clr_value  input  DATA_WIDTH  fill value, sampled with clr_start.
REQ-015 SHALL have port clr_busy  output  1  high while the fill engine owns the write port.
REQ-016 SHALL have port clr_done  output  1  one-cycle pulse when the fill completes.
REQ-017 SHALL have port wr_drop  output  1  one-cycle pulse, asserted the cycle after an external write is discarded.

Function
REQ-018 SHALL store DEPTH x DATA_WIDTH words in one inferred simple-dual-port block RAM; contents are not reset.
REQ-019 SHALL, when we=1 and clr_busy=0, write wd to wa on that edge.
REQ-020 SHALL, with OUT_REG=0, present mem[ra] on rd with rd_valid=1 one cycle after re=1; with OUT_REG=1, two cycles after.
REQ-021 SHALL accept back-to-back reads every cycle; rd_valid pulses once per accepted read, in order.
REQ-022 SHALL hold rd at its last value when no read completes.
REQ-023 SHALL implement fill FSM IDLE -> FILL -> DONE -> IDLE.
REQ-024 IDLE: clr_start=1 latches clr_value, clears address counter to 0, enters FILL; clr_busy goes high the next cycle.
REQ-025 FILL: writes latched value to counter address each cycle, counter +1; after writing DEPTH-1 (counter wrap), enters DONE; fill takes exactly DEPTH cycles.
REQ-026 DONE: clr_done=1 for one cycle, clr_busy=0, returns to IDLE.
REQ-027 SHALL ignore clr_start in FILL or DONE.
REQ-028 SHALL discard external writes while clr_busy=1 and pulse wr_drop the following cycle.
REQ-029 SHALL service reads normally during FILL; read of an address not yet filled returns old contents.
REQ-030 SHALL, when clr_start and we coincide in IDLE, perform the external write that cycle and start the fill (the fill later overwrites it).

Reset
REQ-031 SHALL on reset force FSM=IDLE, counter=0, rd=0, rd_valid=0, clr_busy=0, clr_done=0, wr_drop=0, and flush read pipeline.
REQ-032 Reset mid-fill SHALL abort the fill with no clr_done; partially filled contents remain.

Configuration
REQ-033 Macro VRAM_SDP_BYPASS_EN: when defined, a read to the address written on the same edge (external or fill) SHALL return the new data via a forwarding path.
REQ-034 Without VRAM_SDP_BYPASS_EN, such a read SHALL return the old data (read-before-write).

Verification
REQ-035 OUT_REG=1: write 0xA5 @0x010, next cycle re @0x010 -> rd=0xA5, rd_valid=1 exactly 2 cycles after re.
REQ-036 OUT_REG=0: reads @0,1,2 on consecutive cycles holding 0x11,0x22,0x33 -> rd 0x11,0x22,0x33 on consecutive cycles, rd_valid high 3 cycles.
REQ-037 clr_start with clr_value=0x20 (ADDR_WIDTH=10) -> clr_busy high 1024 cycles, clr_done single pulse; reads of 0x000 and 0x3FF return 0x20.
REQ-038 we=1 during FILL -> wr_drop pulse next cycle, target word equals fill value after done; second clr_start during FILL ignored.
REQ-039 Same-cycle we @0x005 wd=0x7E and re @0x005, old 0x00 -> 0x7E with VRAM_SDP_BYPASS_EN, 0x00 without.
REQ-040 reset asserted at fill cycle 100 -> all outputs 0 immediately, no clr_done, words 0..99 filled, word 0x200 unchanged.
